spi_xfer_ctrl: RTL and testbench

Transaction sequencer that sits between a requester (command/bus logic) and the byte-level SPI_Master engine. It turns one start request plus a byte count into a framed SPI transaction. It owns chip select with setup, hold and idle timing, streams TX bytes into the master one at a time, and returns each received byte to the requester.

---
 rtl/spi_xfer_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI transaction sequencer: frames chip select around a counted byte burst and
// hands bytes to/from a byte-level SPI master. Optional watchdog: XFER_TIMEOUT_EN.
module spi_xfer_ctrl #(
  parameter int COUNT_W       = 8,
  parameter int CS_SETUP_CLKS = 4,
  parameter int CS_HOLD_CLKS  = 4,
  parameter int CS_IDLE_CLKS  = 8,
  parameter int TIMEOUT_CLKS  = 1024
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Start,
  input  logic [COUNT_W-1:0] i_Byte_Count,
  output logic               o_Busy,
  input  logic [7:0]         i_TX_Byte,
  input  logic               i_TX_Valid,
  output logic               o_TX_Accept,
  output logic [7:0]         o_RX_Byte,
  output logic               o_RX_DV,
  output logic               o_Done,
  output logic               o_Error,
  output logic [7:0]         o_M_TX_Byte,
  output logic               o_M_TX_DV,
  input  logic               i_M_TX_Ready,
  input  logic               i_M_RX_DV,
  input  logic [7:0]         i_M_RX_Byte,
  output logic               o_SPI_CS_n
);

  if (CS_SETUP_CLKS < 1 || CS_HOLD_CLKS < 1 || CS_IDLE_CLKS < 1 || TIMEOUT_CLKS < 1) begin : g_param_check
    $error("spi_xfer_ctrl: timing parameters must all be at least 1");
  end

  // One shared phase timer covers setup, hold and idle gap.
  localparam int TMR_MAX_A = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int TMR_MAX   = (TMR_MAX_A > CS_IDLE_CLKS) ? TMR_MAX_A : CS_IDLE_CLKS;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP_CLKS - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD_CLKS - 1);
  localparam logic [TMR_W-1:0] IDLE_LAST  = TMR_W'(CS_IDLE_CLKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_WAIT_DATA, ST_WAIT_RX, ST_HOLD, ST_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic               cs_n_q, cs_n_d;
  logic               busy_q, busy_d;
  logic               tx_accept_q, tx_accept_d;
  logic               rx_dv_q, rx_dv_d;
  logic               done_q, done_d;
  logic               m_tx_dv_q, m_tx_dv_d;
  logic [7:0]         m_tx_byte_q, m_tx_byte_d;
  logic [7:0]         rx_byte_q, rx_byte_d;

`ifdef XFER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CLKS - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            error_q, error_d;
`endif

  always_comb begin
    state_d     = state_q;
    tmr_d       = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
    remaining_d = remaining_q;
    cs_n_d      = cs_n_q;
    busy_d      = busy_q;
    tx_accept_d = 1'b0;
    rx_dv_d     = 1'b0;
    done_d      = 1'b0;
    m_tx_dv_d   = 1'b0;
    m_tx_byte_d = m_tx_byte_q;
    rx_byte_d   = rx_byte_q;
`ifdef XFER_TIMEOUT_EN
    wd_d        = (wd_q == '1) ? wd_q : wd_q + 1'b1;
    error_d     = error_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (i_Start && i_Byte_Count != '0) begin
          remaining_d = i_Byte_Count;
          cs_n_d      = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_SETUP;
`ifdef XFER_TIMEOUT_EN
          error_d     = 1'b0;
`endif
        end
      end
      ST_SETUP: begin
        if (tmr_q == SETUP_LAST) state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (i_TX_Valid && i_M_TX_Ready) begin
          m_tx_byte_d = i_TX_Byte;
          m_tx_dv_d   = 1'b1;
          tx_accept_d = 1'b1;
          state_d     = ST_WAIT_RX;
`ifdef XFER_TIMEOUT_EN
          wd_d        = '0;
`endif
        end
      end
      ST_WAIT_RX: begin
        // Master Ready is not looked at here; it lags our DV by a cycle.
        if (i_M_RX_DV) begin
          rx_byte_d   = i_M_RX_Byte;
          rx_dv_d     = 1'b1;
          remaining_d = (remaining_q == '0) ? '0 : remaining_q - 1'b1;
          if (remaining_q <= COUNT_W'(1)) begin
            state_d = ST_HOLD;
            tmr_d   = '0;
          end else begin
            state_d = ST_WAIT_DATA;
          end
        end
`ifdef XFER_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          error_d     = 1'b1;
          remaining_d = '0;
          state_d     = ST_HOLD;
          tmr_d       = '0;
        end
`endif
      end
      ST_HOLD: begin
        if (tmr_q == HOLD_LAST) begin
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_GAP;
          tmr_d   = '0;
        end
      end
      ST_GAP: begin
        if (tmr_q == IDLE_LAST) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      remaining_q <= '0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      tx_accept_q <= 1'b0;
      rx_dv_q     <= 1'b0;
      done_q      <= 1'b0;
      m_tx_dv_q   <= 1'b0;
      m_tx_byte_q <= 8'h00;
      rx_byte_q   <= 8'h00;
`ifdef XFER_TIMEOUT_EN
      wd_q        <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      remaining_q <= remaining_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      tx_accept_q <= tx_accept_d;
      rx_dv_q     <= rx_dv_d;
      done_q      <= done_d;
      m_tx_dv_q   <= m_tx_dv_d;
      m_tx_byte_q <= m_tx_byte_d;
      rx_byte_q   <= rx_byte_d;
`ifdef XFER_TIMEOUT_EN
      wd_q        <= wd_d;
      error_q     <= error_d;
`endif
    end
  end

  assign o_SPI_CS_n  = cs_n_q;
  assign o_Busy      = busy_q;
  assign o_TX_Accept = tx_accept_q;
  assign o_RX_DV     = rx_dv_q;
  assign o_RX_Byte   = rx_byte_q;
  assign o_Done      = done_q;
  assign o_M_TX_DV   = m_tx_dv_q;
  assign o_M_TX_Byte = m_tx_byte_q;
`ifdef XFER_TIMEOUT_EN
  assign o_Error     = error_q;
`else
  assign o_Error     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: loopback SPI master model, random transactions,
// scoreboard queues for TX/RX bytes and a framing/timing monitor.
module tb_spi_xfer_ctrl;
  localparam int COUNT_W = 8;
  localparam int SETUP   = 4;
  localparam int HOLD    = 4;
  localparam int IDLE    = 8;
  localparam int TMO     = 64;
  localparam int M_CLKS  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  logic [COUNT_W-1:0] i_byte_count = '0;
  logic [7:0] i_tx_byte = 8'h00;
  logic i_tx_valid = 1'b0;
  logic i_m_tx_ready = 1'b1;
  logic i_m_rx_dv = 1'b0;
  logic [7:0] i_m_rx_byte = 8'h00;
  logic o_busy, o_tx_accept, o_rx_dv, o_done, o_error, o_m_tx_dv, o_spi_cs_n;
  logic [7:0] o_rx_byte, o_m_tx_byte;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(
    .COUNT_W(COUNT_W), .CS_SETUP_CLKS(SETUP), .CS_HOLD_CLKS(HOLD),
    .CS_IDLE_CLKS(IDLE), .TIMEOUT_CLKS(TMO)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(i_start), .i_Byte_Count(i_byte_count),
    .o_Busy(o_busy), .i_TX_Byte(i_tx_byte), .i_TX_Valid(i_tx_valid),
    .o_TX_Accept(o_tx_accept), .o_RX_Byte(o_rx_byte), .o_RX_DV(o_rx_dv),
    .o_Done(o_done), .o_Error(o_error), .o_M_TX_Byte(o_m_tx_byte),
    .o_M_TX_DV(o_m_tx_dv), .i_M_TX_Ready(i_m_tx_ready), .i_M_RX_DV(i_m_rx_dv),
    .i_M_RX_Byte(i_m_rx_byte), .o_SPI_CS_n(o_spi_cs_n)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_at_edge <= rst;
  end

  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] tx_buf[$];
  int starts_issued = 0;
  int cs_falls = 0;
  int done_cnt = 0;
  int rx_extra = 0;
  int tx_extra = 0;
  int stray_req = 0;
  int stray_sent = 0;
  logic master_mute = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
  endtask

  // SPI master model: Ready drops after DV, loopback byte returns M_CLKS later.
  int m_cnt = 0;
  int m_ready_dly = 0;
  logic m_busy = 1'b0;
  logic [7:0] m_byte = 8'h00;
  always @(negedge clk) begin
    i_m_rx_dv = 1'b0;
    if (rst || rst_at_edge) begin
      m_busy = 1'b0;
      m_ready_dly = 0;
      i_m_tx_ready = 1'b1;
    end else if (o_m_tx_dv) begin
      check("dv_only_when_ready", i_m_tx_ready, 1'b1);
      check("dv_only_with_cs_low", o_spi_cs_n, 1'b0);
      i_m_tx_ready = 1'b0;
      m_busy = 1'b1;
      m_cnt = M_CLKS;
      m_byte = o_m_tx_byte;
    end else if (m_busy) begin
      if (m_cnt > 0) m_cnt--;
      if (master_mute) begin
        if (o_done) begin
          m_busy = 1'b0;
          i_m_tx_ready = 1'b1;
        end
      end else if (m_cnt == 0) begin
        i_m_rx_dv = 1'b1;
        i_m_rx_byte = m_byte;
        m_busy = 1'b0;
        m_ready_dly = 2;
      end
    end else if (m_ready_dly > 0) begin
      m_ready_dly--;
      if (m_ready_dly == 0) i_m_tx_ready = 1'b1;
    end else if (stray_req != stray_sent) begin
      i_m_rx_dv = 1'b1;
      i_m_rx_byte = 8'h5A;
      stray_sent++;
    end
  end

  // Monitor: scoreboard pops plus chip-select framing and timing.
  logic prev_cs_n = 1'b1;
  logic prev_busy = 1'b0;
  logic first_dv_pending = 1'b0;
  int t_fall = 0;
  int t_rx = 0;
  int t_rise = 0;
  always @(negedge clk) begin
    if (rst_at_edge) begin
      first_dv_pending = 1'b0;
    end else begin
      if (prev_cs_n && !o_spi_cs_n) begin
        check("cs_fall_has_start", cs_falls < starts_issued, 1'b1);
        check("busy_with_cs_fall", o_busy, 1'b1);
        cs_falls++;
        t_fall = cyc;
        first_dv_pending = 1'b1;
      end
      if (o_m_tx_dv || o_tx_accept) begin
        check("accept_matches_dv", o_tx_accept, o_m_tx_dv);
        if (exp_tx_q.size() == 0) tx_extra++;
        else check("tx_byte", o_m_tx_byte, exp_tx_q.pop_front());
        if (first_dv_pending) check_range("setup_time", cyc - t_fall, SETUP, 1 << 30);
        first_dv_pending = 1'b0;
      end
      if (o_rx_dv) begin
        if (exp_rx_q.size() == 0) rx_extra++;
        else check("rx_byte", o_rx_byte, exp_rx_q.pop_front());
        t_rx = cyc;
      end
      if (!prev_cs_n && o_spi_cs_n) begin
        check("done_with_cs_rise", o_done, 1'b1);
        check_range("hold_time", cyc - t_rx, HOLD, 1 << 30);
        t_rise = cyc;
      end else if (o_done) begin
        check("done_only_at_cs_rise", !prev_cs_n && o_spi_cs_n, 1'b1);
      end
      if (o_done) done_cnt++;
      if (prev_busy && !o_busy) check("idle_gap_len", cyc - t_rise, IDLE);
    end
    prev_cs_n = o_spi_cs_n;
    prev_busy = o_busy;
  end

  // mode 0: normal; mode 1: master mute (timeout); mode 2: reset after byte 2.
  task automatic run_xfer(input int mode, input int stall_idx, input int stall_len, input bit busy_start);
    int n = tx_buf.size();
    int serve_n = (mode == 1) ? 1 : (mode == 2) ? 2 : n;
    int d0 = done_cnt;
    int w;
    int t0;
    foreach (tx_buf[i]) begin
      exp_tx_q.push_back(tx_buf[i]);
      if (mode != 1) exp_rx_q.push_back(tx_buf[i]);
    end
    @(negedge clk);
    i_start = 1'b1;
    i_byte_count = COUNT_W'(n);
    starts_issued++;
    @(negedge clk);
    i_start = 1'b0;
    i_byte_count = COUNT_W'($urandom);
    check("cs_low_after_start", o_spi_cs_n, 1'b0);
    check("error_clear_on_start", o_error, 1'b0);
    for (int i = 0; i < serve_n; i++) begin
      if (i == stall_idx) begin
        for (int s = 0; s < stall_len; s++) begin
          if (busy_start && s == stall_len / 2) begin
            i_start = 1'b1;
            i_byte_count = COUNT_W'(5);
          end
          @(negedge clk);
          i_start = 1'b0;
        end
        check("cs_low_during_stall", o_spi_cs_n, 1'b0);
        check("no_dv_during_stall", exp_tx_q.size(), n - i);
      end
      i_tx_valid = 1'b1;
      i_tx_byte = tx_buf[i];
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!o_tx_accept && w < 2000);
      check("tx_accept_seen", o_tx_accept, 1'b1);
      i_tx_valid = 1'b0;
      i_tx_byte = 8'($urandom);
      if (!o_tx_accept) break;
    end
    t0 = cyc;
    if (mode == 2) begin
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_cs_high", o_spi_cs_n, 1'b1);
      check("rst_busy_low", o_busy, 1'b0);
      exp_tx_q.delete();
      exp_rx_q.delete();
      repeat (IDLE + HOLD + 4) @(negedge clk);
      check("rst_no_done", done_cnt - d0, 0);
    end else begin
      if (mode == 1) begin
        w = 0;
        while (!o_error && w < 500) begin
          @(negedge clk);
          w++;
        end
        check_range("timeout_latency", cyc - t0, TMO, TMO + 2);
      end
      w = 0;
      while (o_busy && w < 5000) begin
        @(negedge clk);
        w++;
      end
      check("busy_drops", o_busy, 1'b0);
      check("one_done_per_xfer", done_cnt - d0, 1);
      check("rx_all_returned", exp_rx_q.size(), 0);
      if (mode == 1) begin
        check("error_sticky", o_error, 1'b1);
        check("abandoned_bytes", exp_tx_q.size(), n - 1);
        exp_tx_q.delete();
      end else begin
        check("tx_all_sent", exp_tx_q.size(), 0);
        check("no_error", o_error, 1'b0);
      end
    end
    check("no_unexpected_rx", rx_extra, 0);
    check("no_unexpected_tx", tx_extra, 0);
    tx_buf.delete();
  endtask

  initial begin
    int n;
    int d0;
    repeat (3) @(negedge clk);
    check("reset_cs_n", o_spi_cs_n, 1'b1);
    check("reset_busy", o_busy, 1'b0);
    check("reset_pulses", {o_tx_accept, o_rx_dv, o_done, o_m_tx_dv}, 4'b0000);
    check("reset_error", o_error, 1'b0);
    check("reset_bytes", {o_m_tx_byte, o_rx_byte}, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    tx_buf = '{8'hA5};
    run_xfer(0, -1, 0, 1'b0);
    tx_buf = '{8'h01, 8'h02, 8'h03};
    run_xfer(0, -1, 0, 1'b0);
    tx_buf = '{8'h11, 8'h22, 8'h33};
    run_xfer(0, 1, 50, 1'b1);

    d0 = done_cnt;
    i_start = 1'b1;
    i_byte_count = '0;
    @(negedge clk);
    i_start = 1'b0;
    stray_req++;
    repeat (20) @(negedge clk);
    check("zero_count_cs_idle", o_spi_cs_n, 1'b1);
    check("zero_count_not_busy", o_busy, 1'b0);
    check("zero_count_no_done", done_cnt - d0, 0);
    check("stray_rx_ignored", rx_extra, 0);

    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) tx_buf.push_back(8'($urandom));
      run_xfer(0, $urandom_range(0, n), $urandom_range(1, 12), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 4; i++) tx_buf.push_back(8'($urandom));
    run_xfer(2, -1, 0, 1'b0);
    tx_buf = '{8'hC3, 8'h3C};
    run_xfer(0, -1, 0, 1'b0);

`ifdef XFER_TIMEOUT_EN
    master_mute = 1'b1;
    tx_buf = '{8'h96, 8'h69};
    run_xfer(1, -1, 0, 1'b0);
    master_mute = 1'b0;
    repeat (4) @(negedge clk);
    tx_buf = '{8'h7E};
    run_xfer(0, -1, 0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, %0d/%0d checks passed", passed, checks);
    $fatal(1, "bench timeout");
  end

endmodule
